// File: rtl/fpmul_pkg.sv
// Shared constants for the FP multiplier feeder: widths, FSM encoding, timeout result.
package fpmul_pkg;

  localparam int unsigned FP_WIDTH = 32;
  localparam logic [31:0] FP_QNAN  = 32'h7FFFFFFF;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

endpackage

// File: rtl/fpmul_opfifo.sv
// Operand-pair FIFO with wrapping pointers and a registered full flag.
module fpmul_opfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q;
  logic             do_push, do_pop;

  // Gated by the registered flag, so a same-cycle pop never frees a slot early.
  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign empty = (count_q == '0);
  assign full  = full_q;

endmodule

// File: rtl/fpmul_feeder.sv
// Feeds queued operand pairs to an external FP multiplier one at a time and holds each result.
// Optional watchdog on the multiplier wait is enabled with FPMUL_FEEDER_WDOG_EN.
module fpmul_feeder
  import fpmul_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WDOG_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] in_op1,
  input  logic [FP_WIDTH-1:0] in_op2,
  output logic                mul_ready,
  output logic [FP_WIDTH-1:0] mul_op1,
  output logic [FP_WIDTH-1:0] mul_op2,
  input  logic [FP_WIDTH-1:0] mul_res,
  input  logic                mul_done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] out_res,
  output logic                out_err
);

  logic [1:0]            state_q, state_d;
  logic                  fifo_empty, fifo_full, pop;
  logic [2*FP_WIDTH-1:0] fifo_head;
  logic [FP_WIDTH-1:0]   op1_q, op2_q, res_q;
  logic                  valid_q;
  logic                  wdog_hit;

  fpmul_opfifo #(
    .DEPTH(DEPTH),
    .WIDTH(2 * FP_WIDTH)
  ) u_opfifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid),
    .pop  (pop),
    .wdata({in_op1, in_op2}),
    .rdata(fifo_head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign in_ready = !fifo_full;
  assign pop      = (state_q == StIdle) && !fifo_empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mul_done || wdog_hit) state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) {op1_q, op2_q} <= fifo_head;
      if (state_q == StWait && mul_done) begin
        res_q   <= mul_res;
        valid_q <= 1'b1;
      end else if (wdog_hit) begin
        res_q   <= FP_QNAN;
        valid_q <= 1'b1;
      end else if (state_q == StHold && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef FPMUL_FEEDER_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog_q;
  logic          err_q;

  // mul_done wins over a timeout landing in the same cycle.
  assign wdog_hit = (state_q == StWait) && !mul_done && (wdog_q == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        wdog_q <= '0;
      end else if (state_q == StWait) begin
        wdog_q <= wdog_q + 1'b1;
      end
      if (state_q == StWait && mul_done) begin
        err_q <= 1'b0;
      end else if (wdog_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_err = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = |WDOG_CYCLES;
  assign wdog_hit    = 1'b0;
  assign out_err     = 1'b0;
`endif

  assign mul_ready = (state_q == StIssue);
  assign mul_op1   = op1_q;
  assign mul_op2   = op2_q;
  assign out_valid = valid_q;
  assign out_res   = res_q;

endmodule

// File: tb/tb_fpmul_feeder.sv
// Directed bench for fpmul_feeder with a behavioural multiplier and a result scoreboard.
module tb_fpmul_feeder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WDOG  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_op1, in_op2;
  logic        mul_ready, mul_done;
  logic [31:0] mul_op1, mul_op2, mul_res;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_res;

  fpmul_feeder #(
    .DEPTH(DEPTH),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op1   (in_op1),
    .in_op2   (in_op2),
    .mul_ready(mul_ready),
    .mul_op1  (mul_op1),
    .mul_op2  (mul_op2),
    .mul_res  (mul_res),
    .mul_done (mul_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_res = 0;
  logic [32:0] sb_q[$];

  // Hand-computed single-precision products.
  logic [31:0] t_a [8] = '{32'h40000000, 32'h3FC00000, 32'h40800000, 32'hBF800000,
                           32'h40200000, 32'h40400000, 32'h3F800000, 32'h3E800000};
  logic [31:0] t_b [8] = '{32'h40400000, 32'h40000000, 32'h3F000000, 32'h40A00000,
                           32'h40800000, 32'h40400000, 32'h40E00000, 32'h41000000};
  logic [31:0] t_p [8] = '{32'h40C00000, 32'h40400000, 32'h40000000, 32'hC0A00000,
                           32'h41200000, 32'h41100000, 32'h40E00000, 32'h40000000};

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++) begin
      if (t_a[i] == a && t_b[i] == b) return t_p[i];
    end
    return 32'hDEADBEEF;
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural multiplier; spur injects stray completion pulses.
  int          mul_lat = 1;
  bit          nodone  = 1'b0;
  int          mcnt;
  logic        m_done, spur;
  logic [31:0] m_res, spur_res;

  assign mul_done = m_done | spur;
  assign mul_res  = spur ? spur_res : m_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt   <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (mul_ready) begin
        mcnt <= nodone ? 0 : mul_lat;
      end else if (mcnt == 1) begin
        m_done <= 1'b1;
        m_res  <= fmul(mul_op1, mul_op2);
        mcnt   <= 0;
      end else if (mcnt > 1) begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Monitor: samples handshakes that complete at the following rising edge.
  logic        pv = 1'b0, phs = 1'b0;
  logic [31:0] pres = '0;
  logic [32:0] exp_r;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      sb_q.delete();
      pv = 1'b0;
    end else begin
      if (pv && !phs) check("hold_stable", {out_valid, out_res}, {1'b1, pres});
      if (in_valid && in_ready)
        sb_q.push_back(nodone ? {1'b1, 32'h7FFFFFFF} : {1'b0, fmul(in_op1, in_op2)});
      if (out_valid && out_ready) begin
        exp_r = (sb_q.size() != 0) ? sb_q.pop_front() : 33'bx;
        check("result_order", {out_err, out_res}, exp_r);
        n_res++;
      end
      pv   = out_valid;
      phs  = out_valid && out_ready;
      pres = out_res;
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int lim);
    int c = 0;
    while (!out_valid && c < lim) begin
      @(negedge clk);
      c++;
    end
    check("wait_valid", out_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc, pulses, acc, idx, base;
    bit seen;
    rst = 1'b0; in_valid = 1'b0; in_op1 = '0; in_op2 = '0;
    out_ready = 1'b1; spur = 1'b0; spur_res = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_mul_ready", mul_ready, 1'b0);
    check("rst_mul_ops", {mul_op1, mul_op2}, '0);
    check("rst_out", {out_valid, out_err, out_res}, '0);
    rst = 1'b1;
    @(negedge clk);

    // 2.0 * 3.0, latency and single start pulse
    drive(32'h40000000, 32'h40400000);
    cyc = 0; pulses = 0;
    while (!out_valid && cyc < 20) begin
      if (mul_ready) pulses++;
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 4);
    check("mul_pulses", pulses, 1);
    check("prod_2x3", {out_err, out_res}, {1'b0, 32'h40C00000});
    @(negedge clk);

    // Stray mul_done while idle
    spur = 1'b1; spur_res = 32'h12345678;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("idle_spur_valid", {out_valid, mul_ready}, 2'b00);
    check("idle_spur_res", out_res, 32'h40C00000);

    // Stray mul_done while holding a result
    out_ready = 1'b0;
    drive(32'h3FC00000, 32'h40000000);
    wait_valid(20);
    spur = 1'b1; spur_res = 32'h12345678;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("hold_spur", {out_valid, out_err, out_res}, {2'b10, 32'h40400000});
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release", out_valid, 1'b0);

    // Fill with downstream stalled
    out_ready = 1'b0; acc = 0; idx = 0;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_op1   = t_a[idx % 8];
      in_op2   = t_b[idx % 8];
      if (in_ready) begin
        acc++;
        idx++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("fill_accepted", acc, DEPTH + 1);
    check("fill_in_ready", in_ready, 1'b0);
    base = n_res;
    out_ready = 1'b1;
    for (int k = 0; k < 80 && n_res < base + acc; k++) @(negedge clk);
    repeat (8) @(negedge clk);
    check("fill_drained", n_res - base, DEPTH + 1);
    check("fill_sb_empty", sb_q.size(), 0);
    check("fill_idle", out_valid, 1'b0);

    // Back-to-back products with random downstream stalls
    mul_lat = 2; base = n_res; idx = 0;
    for (int k = 0; k < 300 && n_res < base + 5; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (idx < 5) begin
        in_valid = 1'b1;
        in_op1   = t_a[(idx + 3) % 8];
        in_op2   = t_b[(idx + 3) % 8];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_count", n_res - base, 5);

`ifdef FPMUL_FEEDER_WDOG_EN
    // Multiplier never completes
    nodone = 1'b1; out_ready = 1'b0;
    drive(32'h40200000, 32'h40800000);
    cyc = 0;
    while (!mul_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("wdog_issue", mul_ready, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 4 * WDOG) begin
      @(negedge clk);
      cyc++;
    end
    check("wdog_cycles", cyc, WDOG + 1);
    check("wdog_result", {out_err, out_res}, {1'b1, 32'h7FFFFFFF});
    out_ready = 1'b1;
    @(negedge clk);
    nodone = 1'b0;
    drive(32'h3F800000, 32'h40E00000);
    wait_valid(20);
    check("wdog_after", {out_err, out_res}, {1'b0, 32'h40E00000});
    @(negedge clk);
`endif

    // Reset while waiting on the multiplier with three pairs queued
    mul_lat = 30; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_op1   = t_a[k];
      in_op2   = t_b[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {in_ready, out_valid}, 2'b10);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_mul", {mul_ready, mul_op1, mul_op2}, '0);
    check("mid_rst_out", {out_valid, out_err, out_res}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1; mul_lat = 1; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid || mul_ready) seen = 1'b1;
    end
    check("no_out_after_rst", seen, 1'b0);
    check("post_rst_in_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpmul_feeder.md
FPMUL_FEEDER -- requirements
Module: fpmul_feeder

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO depth; power of two, at least 2.
REQ-002 Parameter WDOG_CYCLES, default 32, watchdog limit in clk cycles spent in WAIT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  FIFO can accept a pair; equals !full.
REQ-007 in_op1, in_op2  input  32  IEEE754 single-precision operands.
REQ-008 mul_ready  output  1  start pulse to the multiplier.
REQ-009 mul_op1, mul_op2  output  32  operands to the multiplier, registered.
REQ-010 mul_res  input  32  multiplier result.
REQ-011 mul_done  input  1  multiplier completion pulse.
REQ-012 out_valid  output  1  result available downstream.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_res  output  32  product, registered.
REQ-015 out_err  output  1  result produced by watchdog timeout.

Function
REQ-016 A pair shall be pushed into the FIFO when in_valid && in_ready; the FIFO holds DEPTH pairs with wrapping pointers and a count of width clog2(DEPTH)+1.
REQ-017 The FSM states shall be IDLE, ISSUE, WAIT and HOLD.
REQ-018 IDLE->ISSUE when the FIFO is non-empty; otherwise stay in IDLE.
REQ-019 On the IDLE->ISSUE edge, mul_op1/mul_op2 shall load the FIFO head and the FIFO shall pop.
REQ-020 mul_ready shall be 1 only while in ISSUE, for exactly one cycle; ISSUE->WAIT unconditionally.
REQ-021 mul_op1/mul_op2 shall remain stable from ISSUE until the next pop.
REQ-022 In WAIT, when mul_done=1, out_res shall load mul_res, out_err shall load 0, out_valid shall rise and the FSM shall move to HOLD.
REQ-023 In HOLD, when out_ready=1, out_valid shall fall and the FSM shall move to IDLE; out_res is held while out_valid=1.
REQ-024 mul_done outside WAIT shall be ignored.
REQ-025 Push while the FSM pops in the same cycle shall be legal when not full; count is unchanged.
REQ-026 in_ready shall use the registered full flag, so no push occurs on a full FIFO even when a pop happens that cycle.
REQ-027 Results shall leave in the same order that operands entered.
REQ-028 Minimum latency, from push into an empty idle block to out_valid, is 2 cycles plus the multiplier latency.

Reset
REQ-029 While rst=0: FSM=IDLE, FIFO empty, in_ready=1, mul_ready=0, mul_op1=mul_op2=0, out_valid=0, out_res=0, out_err=0, watchdog count=0.
REQ-030 Reset mid-operation shall discard the in-flight operation and all queued pairs, with no output produced.
REQ-031 The multiplier shall be driven by the same reset, inverted to its active-high input at integration.

Configuration
REQ-032 With FPMUL_FEEDER_WDOG_EN defined, a counter shall run while in WAIT and clear on entry to WAIT.
REQ-033 With FPMUL_FEEDER_WDOG_EN defined, when the count reaches WDOG_CYCLES without mul_done: out_res=32'h7FFFFFFF, out_err=1, FSM->HOLD.
REQ-034 With FPMUL_FEEDER_WDOG_EN defined, a simultaneous timeout and mul_done shall take mul_done.
REQ-035 Without FPMUL_FEEDER_WDOG_EN, no counter shall exist, out_err shall be constant 0 and WAIT shall wait indefinitely.

Structure
REQ-036 A shared package fpmul_pkg shall hold the state encoding, the FP_QNAN constant 32'h7FFFFFFF and the FP_WIDTH=32 constant.
REQ-037 The FIFO shall be the single sub-module fpmul_opfifo, parameterised by DEPTH and 64-bit data.

Verification
REQ-038 Push 0x40000000, 0x40400000 (2.0*3.0) with out_ready=1 -> single mul_ready pulse, out_res=0x40C00000, out_err=0.
REQ-039 out_ready=0, continuous in_valid -> in_ready falls after exactly DEPTH+1 accepted pairs; no pair lost or duplicated.
REQ-040 Five back-to-back products with random out_ready stalls -> results in input order, out_res stable while out_valid=1.
REQ-041 rst asserted during WAIT with 3 queued pairs -> outputs at reset values immediately; no out_valid after release.
REQ-042 With FPMUL_FEEDER_WDOG_EN, mul_done forced low -> out_valid at WAIT cycle WDOG_CYCLES with out_res=0x7FFFFFFF, out_err=1.
REQ-043 Spurious mul_done pulse in IDLE or HOLD -> no state or output change.
